// File: rtl/mfu_acc.sv
// Product unpack-and-accumulate stage for the mFU multiplier: splits packed products into lanes,
// sums them per beat and accumulates across a group. Define MFU_ACC_SAT_EN for saturating accumulation.
module mfu_acc #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [15:0]      in_p,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_beats,
    output logic             out_ovf,
    output logic             state_dbg
);

    // Handshakes: a beat moves on in_valid & in_ready, a result on out_valid & out_ready;
    // valid never waits on ready and payloads are held stable while valid is high.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             grp_ovf;

    logic [ACC_W-1:0] beat;
    logic [ACC_W-1:0] acc_nxt;
    logic [7:0]       cnt_nxt;
    logic             clamp;
    logic             ovf_nxt;
    logic             take;

    assign in_ready  = ~out_valid | out_ready;
    assign take      = in_valid & in_ready;
    assign state_dbg = state;

    always_comb begin
        beat = '0;
        unique case (in_mode)
            2'b01: beat = {{(ACC_W-16){in_p[15]}}, in_p};
            2'b10: beat = {{(ACC_W-8){in_p[15]}}, in_p[15:8]}
                        + {{(ACC_W-8){in_p[7]}},  in_p[7:0]};
            2'b11: beat = {{(ACC_W-4){in_p[15]}}, in_p[15:12]}
                        + {{(ACC_W-4){in_p[11]}}, in_p[11:8]}
                        + {{(ACC_W-4){in_p[7]}},  in_p[7:4]}
                        + {{(ACC_W-4){in_p[3]}},  in_p[3:0]};
            default: beat = '0;
        endcase
    end

`ifdef MFU_ACC_SAT_EN
    logic [ACC_W:0] wide;
    assign wide = {acc[ACC_W-1], acc} + {beat[ACC_W-1], beat};

    // Top two bits disagree exactly when the signed sum left the ACC_W range.
    always_comb begin
        acc_nxt = wide[ACC_W-1:0];
        clamp   = 1'b0;
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            clamp   = 1'b1;
            acc_nxt = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign acc_nxt = acc + beat;
    assign clamp   = 1'b0;
`endif

    assign ovf_nxt = grp_ovf | clamp;
    assign cnt_nxt = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            grp_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            grp_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (take) begin
                if (in_last) begin
                    out_sum   <= acc_nxt;
                    out_beats <= cnt_nxt;
                    out_ovf   <= ovf_nxt;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    grp_ovf   <= 1'b0;
                    state     <= IDLE;
                end else begin
                    acc     <= acc_nxt;
                    cnt     <= cnt_nxt;
                    grp_ovf <= ovf_nxt;
                    state   <= ACCUM;
                end
            end
        end
    end

endmodule

// File: doc/mfu_acc.md
# mfu_acc

Product unpack-and-accumulate stage on the consuming side of the precision-scalable multiplier `mFU`. It accepts the packed 16-bit product word with its mode, splits it into 1, 2 or 4 signed lanes, sums the lanes and accumulates them across a group of beats. At the beat flagged `in_last` it presents the dot-product result on a valid/ready output.

## Interface
- `ACC_W`, default 24: accumulator and result width, signed; legal range 18..32.
- `clk`  in  1  clock, rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous clear of the group and of any pending result.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `in_mode`  in  2  00 NOOP, 01 one 16b product, 10 two 8b products, 11 four 4b products.
- `in_p`  in  16  packed product, in the same layout the multiplier produces.
- `in_last`  in  1  final beat of the group.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `out_sum`  out  ACC_W  signed group sum.
- `out_beats`  out  8  beats in the group, including NOOPs; saturates at 255.
- `out_ovf`  out  1  saturation occurred in the group; tied 0 without `MFU_ACC_SAT_EN`.

## Operation
- Lane split:
  - mode 01: one lane, `in_p[15:0]`.
  - mode 10: two lanes, `in_p[15:8]` and `in_p[7:0]`.
  - mode 11: four lanes, `in_p[15:12]`, `[11:8]`, `[7:4]` and `[3:0]`.
  - mode 00: contributes 0 but still counts as a beat.
- Each lane is sign-extended to ACC_W. The beat value is the sum of its lanes. Modes may differ beat to beat within a group.
- State machine, input side:
  - IDLE: accumulator 0, beat count 0.
  - IDLE → ACCUM on an accepted non-last beat.
  - ACCUM → ACCUM on each accepted non-last beat: `acc += beat`, count += 1.
  - IDLE or ACCUM → IDLE on an accepted last beat. The result register loads `acc + beat`, count+1 and the ovf flag; `out_valid` is set; the accumulator, count and ovf are cleared.
- Output side: `out_valid` holds, with `out_sum`, `out_beats` and `out_ovf` stable, until `out_ready`.
- `in_ready = ~out_valid | out_ready`. A last beat accepted in the same cycle as a drain reloads the result and `out_valid` stays 1.
- `clr`: the state returns to IDLE, `out_valid` goes to 0 and any beat offered that cycle is dropped. `clr` has priority over every other event.
- Arithmetic:
  - Without `MFU_ACC_SAT_EN`: two's-complement wrap at ACC_W.
  - With `MFU_ACC_SAT_EN`: as defined under Configuration.

## Timing
- Reset values: `out_valid` 0, `out_sum` 0, `out_beats` 0, `out_ovf` 0, state IDLE. `in_ready` is 1 out of reset, because it is combinational from `out_valid` and `out_ready`.
- Latency: a last beat accepted at edge N gives `out_valid` high after edge N, so the result is visible in the cycle following acceptance.
- Throughput: one beat per cycle while no result is pending or while the pending result drains every cycle.
- Reset asserted mid-group: the accumulator and any pending result are discarded immediately. No partial result is emitted.
- Beat count at 255: it stays at 255 while accumulation continues.

## Configuration
- `MFU_ACC_SAT_EN` defined:
  - Each accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp in the group sets a sticky flag, reported on `out_ovf` with the result.
- Undefined: accumulation wraps and `out_ovf` is constant 0.

## Test plan
- Mode 01: `in_p` = 16'hFF38 (-200) twice, `in_last` on the second → `out_sum` = -400, `out_beats` = 2, one cycle after the last beat.
- Mixed modes, `in_last` on the third beat → `out_sum` = -2, `out_beats` = 3:
  - mode 11, `in_p` = 16'h7F18 → lanes 7, -1, 1, -8, beat sum -1;
  - mode 10, `in_p` = 16'h807F → lanes -128, 127, beat sum -1;
  - mode 00 → beat sum 0.
- Backpressure: hold `out_ready` = 0 with a result pending → `in_ready` = 0 and the result stays stable. Raise `out_ready` together with a new last beat (mode 01, value 5) → `out_valid` stays 1 and `out_sum` = 5.
- ACC_W = 18, five mode 01 beats of 16'h7FFF:
  - without the macro: `out_sum` = -98309, `out_ovf` = 0;
  - with the macro: `out_sum` = 131071, `out_ovf` = 1.
- Mid-group abort: three beats of 16'h0010 (mode 01), then pulse `nrst` low. Then one last beat of value 3 → `out_sum` = 3, `out_beats` = 1. Repeat the sequence using `clr` instead of `nrst` → same result.
- NOOP-only group: a single mode 00 beat with `in_last` → `out_sum` = 0, `out_beats` = 1.
